instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Byte-serial instruction fetch stage that sits directly upstream of the multicycle controller. It reads 8-bit instruction bytes from program memory over a req/ack handshake and assembles one- or two-byte instructions. Completed instructions are presented in a single-entry output buffer with a valid/ready handshake. It owns the PC and accepts branch redirects from the controller.

Parameters:
ADDR_W, 13, program address width; 2-byte instruction address = {op[4:0], tr[7:0]}.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
fetch_en  input  1  permit new instruction fetches.
mem_req  output  1  memory read request.
mem_addr  output  ADDR_W  read address, stable while mem_req high.
mem_rdata  input  8  read data, valid in the cycle mem_ack is high.
mem_ack  input  1  read complete; may be high in the same cycle as mem_req.
instr_valid  output  1  output buffer holds a complete instruction.
instr_ready  input  1  controller accepts the instruction.
instr_op  output  8  first byte (IR).
instr_tr  output  8  second byte (TR); 0 for one-byte instructions.
instr_len2  output  1  instruction is two bytes.
instr_pc  output  ADDR_W  address of the first byte.
redirect_en  input  1  load PC from redirect_addr and flush.
redirect_addr  input  ADDR_W  branch target.
busy  output  1  state != IDLE or instr_valid.

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_PC; mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr_op=0, instr_tr=0, instr_len2=0, instr_pc=0, busy=0.
- Length decode on byte 1: two-byte if op[7]==0 or op[7:5]==3'b110; otherwise one-byte.
- Transfer = instr_valid && instr_ready at a rising edge. The buffer is free when instr_valid==0 or a transfer occurs this cycle.
- States:
  - IDLE: mem_req=0. Go to REQ1 when fetch_en=1 and the buffer is free.
  - REQ1: mem_req=1, mem_addr=pc. On ack: latch op, record instr_pc=pc, pc=pc+1.
    - Two-byte: go to REQ2.
    - One-byte: load the buffer, set instr_valid. Go to REQ1 if fetch_en=1, else IDLE.
  - REQ2: mem_req=1, mem_addr=pc. On ack: tr=mem_rdata, pc=pc+1, load the buffer (len2=1). Go to REQ1 if fetch_en=1, else IDLE.
  - HOLD: buffer full and not draining; mem_req=0. Reached from REQ1/REQ2 instead of REQ1 when the buffer is still occupied. Leave to REQ1 on a transfer (fetch_en=1) or to IDLE (fetch_en=0).
  - DRAIN: outstanding request flushed by redirect. Hold mem_req=1 and mem_addr unchanged until ack, discard data, then go to REQ1 (fetch_en=1) or IDLE.
- Buffer load only when the buffer is free. Otherwise the next fetch is not issued: REQ1 is not entered while instr_valid=1 without a transfer.
- Handshake: mem_req stays high with stable mem_addr until ack. Back-to-back requests are allowed (new address the cycle after ack). Never abandon a request mid-flight.
- Latency (ack same cycle as req): one-byte instr_valid 1 cycle after REQ1 entry; two-byte 2 cycles.
- PC arithmetic is modulo 2^ADDR_W; pc=2^ADDR_W-1 wraps to 0, including between byte 1 and byte 2.
- redirect_en (highest priority):
  - Sets pc=redirect_addr and clears instr_valid; a same-cycle transfer is ignored.
  - Discards any partial instruction.
  - If mem_req is high and mem_ack=0 this cycle, go to DRAIN. If acked this cycle, discard the data and go to REQ1/IDLE per fetch_en.
  - Redirect in IDLE just updates pc.
- fetch_en falling mid-instruction: the current instruction completes into the buffer, then IDLE.
- Reset mid-request drops mem_req immediately (memory must tolerate this).

Test Plan:
- Zero-wait memory, mem[0]=8'hE3 (one-byte), instr_ready=1 -> mem_req cycle 0, instr_valid cycle 1, op=E3, len2=0, instr_pc=0, next mem_addr=1.
- mem[5]=8'h12, mem[6]=8'h34, 2-cycle ack latency -> instr_valid after 4 cycles: op=12, tr=34, len2=1, instr_pc=5, pc=7.
- instr_ready=0 for 10 cycles after the first instruction -> exactly one further request completes (stalls in HOLD), instr_op stable, no request while HOLD; ready=1 resumes at the next address.
- Redirect to 0x0100 while a byte-1 request to 0x0010 is unacked -> mem_req/addr 0x0010 held until ack, data dropped, next request addr 0x0100, instr_valid=0 throughout.
- pc=0x1FFF, mem[0x1FFF]=8'hC0, mem[0]=8'hAA -> byte-2 fetch at addr 0, op=C0, tr=AA, len2=1.
- rst=0 asserted mid-REQ2 -> mem_req, instr_valid drop asynchronously; after release, first request addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Byte-serial fetch of 1/2-byte instructions into a one-entry
//               valid/ready output buffer; owns the PC and accepts redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int                ADDR_W   = 13,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_op,
    output logic [7:0]        instr_tr,
    output logic              instr_len2,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ1  = 3'd1,
        S_REQ2  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic [7:0]        pend_op_q, pend_op_d;
    logic [7:0]        pend_tr_q, pend_tr_d;
    logic              pend_len2_q, pend_len2_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              valid_q, valid_d;
    logic [7:0]        op_q, op_d;
    logic [7:0]        tr_q, tr_d;
    logic              len2_q, len2_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;

    logic              done;
    logic [7:0]        done_op;
    logic [7:0]        done_tr;
    logic              done_len2;
    logic [ADDR_W-1:0] done_pc;

    logic transfer;
    logic buf_free;
    logic op_two_byte;

    assign transfer    = valid_q & instr_ready;
    assign buf_free    = ~valid_q | instr_ready;
    assign op_two_byte = ~mem_rdata[7] | (mem_rdata[7:5] == 3'b110);

    assign mem_req     = (state_q == S_REQ1) | (state_q == S_REQ2) | (state_q == S_DRAIN);
    assign mem_addr    = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    assign instr_valid = valid_q;
    assign instr_op    = op_q;
    assign instr_tr    = tr_q;
    assign instr_len2  = len2_q;
    assign instr_pc    = ipc_q;
    assign busy        = (state_q != S_IDLE) | valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        pend_op_d    = pend_op_q;
        pend_tr_d    = pend_tr_q;
        pend_len2_d  = pend_len2_q;
        pend_pc_d    = pend_pc_q;
        valid_d      = valid_q & ~transfer;
        op_d         = op_q;
        tr_d         = tr_q;
        len2_d       = len2_q;
        ipc_d        = ipc_q;
        done         = 1'b0;
        done_op      = pend_op_q;
        done_tr      = 8'h00;
        done_len2    = 1'b0;
        done_pc      = pend_pc_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_en && buf_free) state_d = S_REQ1;
            end
            S_REQ1: begin
                if (mem_ack) begin
                    pend_op_d = mem_rdata;
                    pend_pc_d = pc_q;
                    pc_d      = pc_q + PC_ONE;
                    if (op_two_byte) begin
                        state_d = S_REQ2;
                    end else begin
                        done    = 1'b1;
                        done_op = mem_rdata;
                        done_pc = pc_q;
                    end
                end
            end
            S_REQ2: begin
                if (mem_ack) begin
                    pc_d      = pc_q + PC_ONE;
                    done      = 1'b1;
                    done_tr   = mem_rdata;
                    done_len2 = 1'b1;
                end
            end
            S_HOLD: begin
                if (transfer) begin
                    valid_d = 1'b1;
                    op_d    = pend_op_q;
                    tr_d    = pend_tr_q;
                    len2_d  = pend_len2_q;
                    ipc_d   = pend_pc_q;
                    state_d = fetch_en ? S_REQ1 : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mem_ack) state_d = fetch_en ? S_REQ1 : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A finished instruction that cannot enter the buffer parks in the pending slot.
        if (done) begin
            if (buf_free) begin
                valid_d = 1'b1;
                op_d    = done_op;
                tr_d    = done_tr;
                len2_d  = done_len2;
                ipc_d   = done_pc;
                state_d = fetch_en ? S_REQ1 : S_IDLE;
            end else begin
                pend_op_d   = done_op;
                pend_tr_d   = done_tr;
                pend_len2_d = done_len2;
                pend_pc_d   = done_pc;
                state_d     = S_HOLD;
            end
        end

        if (redirect_en) begin
            pc_d    = redirect_addr;
            valid_d = 1'b0;
            if (state_q == S_IDLE) begin
                state_d = S_IDLE;
            end else if (mem_req && !mem_ack) begin
                state_d      = S_DRAIN;
                drain_addr_d = mem_addr;
            end else begin
                state_d = fetch_en ? S_REQ1 : S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            pend_op_q    <= 8'h00;
            pend_tr_q    <= 8'h00;
            pend_len2_q  <= 1'b0;
            pend_pc_q    <= '0;
            valid_q      <= 1'b0;
            op_q         <= 8'h00;
            tr_q         <= 8'h00;
            len2_q       <= 1'b0;
            ipc_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            pend_op_q    <= pend_op_d;
            pend_tr_q    <= pend_tr_d;
            pend_len2_q  <= pend_len2_d;
            pend_pc_q    <= pend_pc_d;
            valid_q      <= valid_d;
            op_q         <= op_d;
            tr_q         <= tr_d;
            len2_q       <= len2_d;
            ipc_q        <= ipc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed + random bench for instr_fetch_unit with a memory
//               model and an instruction-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int MSIZE = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b0;
    logic        instr_ready = 1'b0;
    logic        redirect_en = 1'b0;
    logic [12:0] redirect_addr = '0;
    logic        mem_req;
    logic [12:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        instr_valid;
    logic [7:0]  instr_op;
    logic [7:0]  instr_tr;
    logic        instr_len2;
    logic [12:0] instr_pc;
    logic        busy;

    logic [7:0]  mem [0:MSIZE-1];
    int          wait_cnt = 0;
    int          rnd_lat = 0;
    bit          rand_mode = 1'b0;
    int          fix_lat = 0;

    int          checks = 0;
    int          errors = 0;
    int          xfers = 0;
    logic [12:0] model_pc = '0;
    bit          pv_pend = 1'b0;
    logic [12:0] pv_addr = '0;
    bit          pv_hold = 1'b0;
    logic [7:0]  pv_op = '0;
    bit          pv_redir = 1'b0;

    instr_fetch_unit #(.ADDR_W(13), .RESET_PC(13'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_tr      (instr_tr),
        .instr_len2    (instr_len2),
        .instr_pc      (instr_pc),
        .redirect_en   (redirect_en),
        .redirect_addr (redirect_addr),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Program memory: ack after a programmable number of wait cycles.
    always_comb begin
        mem_rdata = mem[mem_addr];
        mem_ack   = mem_req && (wait_cnt >= (rand_mode ? rnd_lat : fix_lat));
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 0;
        end else if (mem_req && !mem_ack) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
            if (mem_ack) rnd_lat <= int'($urandom_range(0, 3));
        end
    end

    function automatic bit two_byte(input logic [7:0] op);
        return (op < 8'h80) || (op >= 8'hC0 && op < 8'hE0);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: protocol/scoreboard checks just before the edge, then return at edge+1.
    task automatic tick();
        logic [7:0]  exp_op;
        logic [7:0]  exp_tr;
        logic [12:0] nxt;
        bit          ln;
        @(negedge clk);
        if (rst) begin
            if (pv_pend)  check("addr_hold", {mem_req, mem_addr}, {1'b1, pv_addr});
            if (pv_hold)  check("buf_hold", {instr_valid, instr_op}, {1'b1, pv_op});
            if (pv_redir) check("redir_flush", instr_valid, 1'b0);
            if (redirect_en) begin
                model_pc = redirect_addr;
            end else if (instr_valid && instr_ready) begin
                exp_op = mem[model_pc];
                ln     = two_byte(exp_op);
                nxt    = model_pc + 13'd1;
                exp_tr = ln ? mem[nxt] : 8'h00;
                check("xfer", {instr_op, instr_tr, instr_len2, instr_pc},
                      {exp_op, exp_tr, ln, model_pc});
                model_pc = model_pc + (ln ? 13'd2 : 13'd1);
                xfers++;
            end
            pv_pend  = mem_req && !mem_ack;
            pv_addr  = mem_addr;
            pv_hold  = instr_valid && !instr_ready && !redirect_en;
            pv_op    = instr_op;
            pv_redir = redirect_en;
        end else begin
            pv_pend  = 1'b0;
            pv_hold  = 1'b0;
            pv_redir = 1'b0;
            model_pc = 13'h0000;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        fetch_en    = 1'b0;
        instr_ready = 1'b1;
        redirect_en = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy && !mem_req) break;
            tick();
        end
        check(tag, {busy, mem_req}, 2'b00);
    endtask

    task automatic redirect_idle(input logic [12:0] a);
        redirect_en   = 1'b1;
        redirect_addr = a;
        tick();
        redirect_en   = 1'b0;
    endtask

    initial begin
        int acks;
        for (int i = 0; i < MSIZE; i++) mem[i] = 8'($urandom);
        mem[0]    = 8'hE3;
        mem[5]    = 8'h12;
        mem[6]    = 8'h34;
        mem[32]   = 8'hE3;
        mem[33]   = 8'hE4;
        mem[34]   = 8'hE5;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_addr", {mem_req, mem_addr}, {1'b0, 13'h0000});
        check("rst_buffer", {instr_valid, instr_op, instr_tr, instr_len2, instr_pc},
              {1'b0, 8'h00, 8'h00, 1'b0, 13'h0000});
        check("rst_busy", busy, 1'b0);

        // Zero-wait one-byte fetch
        rst = 1'b1;
        instr_ready = 1'b1;
        tick();
        fetch_en = 1'b1;
        tick();
        check("t1_req", {mem_req, mem_addr}, {1'b1, 13'h0000});
        tick();
        check("t1_buf", {instr_valid, instr_op, instr_tr, instr_len2, instr_pc},
              {1'b1, 8'hE3, 8'h00, 1'b0, 13'h0000});
        check("t1_next_addr", {mem_req, mem_addr}, {1'b1, 13'h0001});
        wait_idle("t1_idle");

        // Two-byte fetch with one wait cycle per byte
        fix_lat = 1;
        redirect_idle(13'h0005);
        fetch_en = 1'b1;
        tick();
        check("t2_req1", {mem_req, mem_addr, mem_ack}, {1'b1, 13'h0005, 1'b0});
        tick();
        tick();
        check("t2_req2", {mem_req, mem_addr}, {1'b1, 13'h0006});
        tick();
        check("t2_not_yet", instr_valid, 1'b0);
        tick();
        check("t2_buf", {instr_valid, instr_op, instr_tr, instr_len2, instr_pc},
              {1'b1, 8'h12, 8'h34, 1'b1, 13'h0005});
        check("t2_pc", mem_addr, 13'h0007);
        wait_idle("t2_idle");

        // Back-pressure: one extra fetch completes, then no requests
        fix_lat = 0;
        instr_ready = 1'b0;
        redirect_idle(13'h0020);
        fetch_en = 1'b1;
        tick();
        tick();
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_ack) acks++;
            check("t3_op_stable", {instr_valid, instr_op}, {1'b1, 8'hE3});
            tick();
        end
        check("t3_acks", acks, 1);
        check("t3_no_req", mem_req, 1'b0);
        instr_ready = 1'b1;
        tick();
        check("t3_resume", {instr_valid, instr_op, instr_pc, mem_req, mem_addr},
              {1'b1, 8'hE4, 13'h0021, 1'b1, 13'h0022});
        wait_idle("t3_idle");

        // Redirect while a request is outstanding
        fix_lat = 3;
        redirect_idle(13'h0010);
        fetch_en = 1'b1;
        tick();
        tick();
        redirect_en   = 1'b1;
        redirect_addr = 13'h0100;
        tick();
        redirect_en = 1'b0;
        check("t4_drain", {mem_req, mem_addr, mem_ack, instr_valid}, {1'b1, 13'h0010, 1'b0, 1'b0});
        tick();
        check("t4_drain_ack", {mem_req, mem_addr, mem_ack, instr_valid}, {1'b1, 13'h0010, 1'b1, 1'b0});
        tick();
        check("t4_target", {mem_req, mem_addr, instr_valid}, {1'b1, 13'h0100, 1'b0});
        wait_idle("t4_idle");

        // PC wrap between byte 1 and byte 2
        mem[0]    = 8'hAA;
        mem[8191] = 8'hC0;
        fix_lat = 0;
        instr_ready = 1'b0;
        redirect_idle(13'h1FFF);
        fetch_en = 1'b1;
        tick();
        check("t5_req1", {mem_req, mem_addr}, {1'b1, 13'h1FFF});
        tick();
        check("t5_wrap_addr", {mem_req, mem_addr}, {1'b1, 13'h0000});
        fetch_en = 1'b0;
        tick();
        check("t5_buf", {instr_valid, instr_op, instr_tr, instr_len2, instr_pc},
              {1'b1, 8'hC0, 8'hAA, 1'b1, 13'h1FFF});
        wait_idle("t5_idle");

        // Asynchronous reset in the middle of the second byte
        fix_lat = 2;
        instr_ready = 1'b0;
        redirect_idle(13'h0005);
        fetch_en = 1'b1;
        repeat (4) tick();
        check("t6_in_req2", {mem_req, mem_addr}, {1'b1, 13'h0006});
        #2 rst = 1'b0;
        #1;
        check("t6_async", {mem_req, instr_valid, busy, mem_addr}, {1'b0, 1'b0, 1'b0, 13'h0000});
        tick();
        rst = 1'b1;
        tick();
        check("t6_restart", {mem_req, mem_addr}, {1'b1, 13'h0000});
        wait_idle("t6_idle");

        // Random traffic against the instruction-stream model
        rand_mode = 1'b1;
        xfers = 0;
        for (int i = 0; i < 3000; i++) begin
            fetch_en    = ($urandom_range(0, 9) != 0);
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect_en = ($urandom_range(0, 49) == 0);
            redirect_addr = ($urandom_range(0, 3) == 0) ? 13'h1FFF : 13'($urandom_range(0, 8191));
            tick();
        end
        wait_idle("t7_idle");
        check("t7_traffic", (xfers > 100), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
